// File: rtl/switch_debouncer_pkg.sv
// Shared types for the switch debouncer: channel FSM encoding, channel-index width helper,
// and the event record layout {chan, rise, repeat}.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } deb_state_e;

  // Widest channel index for the largest legal switch count (16).
  localparam int CHAN_MAX_W = 4;

  typedef struct packed {
    logic [CHAN_MAX_W-1:0] chan;
    logic                  rise;
    logic                  rep;
  } evt_rec_t;

  function automatic int calc_cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce_chan.sv
// One debounce channel: LOW/CHK_HIGH/HIGH/CHK_LOW FSM with registered level and a 1-cycle post pulse.
// Autorepeat of rise events while HIGH is built only with SWITCH_DEBOUNCER_AUTOREPEAT_EN.
module switch_debounce_chan
  import switch_debouncer_pkg::*;
#(
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
  parameter int REPEAT_TICKS = 500,
`endif
  parameter int STABLE_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_s_i,
  input  logic tick_i,
  output logic level_o,
  output logic post_o,
  output logic post_rise_o,
  output logic post_rep_o
);

  localparam int CntW = $clog2(STABLE_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  deb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, post_q, rise_q;

`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
  localparam int RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS - 1);
  logic [RepW-1:0] rcnt_q;
  logic            rep_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      post_q  <= 1'b0;
      rise_q  <= 1'b0;
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      post_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (sw_s_i) begin
            state_q <= ST_CHK_HIGH;
            cnt_q   <= '0;
          end
        end
        ST_CHK_HIGH: begin
          if (!sw_s_i) begin
            state_q <= ST_LOW;
          end else if (tick_i) begin
            if (cnt_q == CntLast) begin
              state_q <= ST_HIGH;
              level_q <= 1'b1;
              post_q  <= 1'b1;
              rise_q  <= 1'b1;
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
              rcnt_q  <= '0;
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (!sw_s_i) begin
            state_q <= ST_CHK_LOW;
            cnt_q   <= '0;
          end
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
          // Repeat cadence runs only while the switch stays settled high.
          else if (tick_i) begin
            if (rcnt_q == RepLast) begin
              rcnt_q <= '0;
              post_q <= 1'b1;
              rise_q <= 1'b1;
              rep_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
`endif
        end
        ST_CHK_LOW: begin
          if (sw_s_i) begin
            state_q <= ST_HIGH;
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
            rcnt_q  <= '0;
`endif
          end else if (tick_i) begin
            if (cnt_q == CntLast) begin
              state_q <= ST_LOW;
              level_q <= 1'b0;
              post_q  <= 1'b1;
              rise_q  <= 1'b0;
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_LOW;
      endcase
    end
  end

  assign level_o     = level_q;
  assign post_o      = post_q;
  assign post_rise_o = rise_q;
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
  assign post_rep_o  = rep_q;
`else
  assign post_rep_o  = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Front-panel switch conditioner: 2-flop sync, shared tick prescaler, per-channel debounce, event stream
// (lowest pending channel first, outputs frozen while stalled). Autorepeat via SWITCH_DEBOUNCER_AUTOREPEAT_EN.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int N_SW         = 4,
  parameter int PRESCALE     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_TICKS = 500,
  localparam int CW          = calc_cw(N_SW)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] STATE,
  output logic            EVT_VALID,
  input  logic            EVT_READY,
  output logic [CW-1:0]   EVT_CHAN,
  output logic            EVT_RISE,
  output logic            EVT_REPEAT,
  output logic            EVT_OVERRUN
);

  localparam int PW = $clog2(PRESCALE);

  if (N_SW < 1 || N_SW > 16 || PRESCALE < 2 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
    $error("switch_debouncer: illegal parameter set");
  end

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [PW-1:0]   pcnt_q;
  logic            tick;
  logic [N_SW-1:0] level, post, post_rise, post_rep;
  logic [N_SW-1:0] pend_q, pend_d, pdir_q, pdir_d, prep_q, prep_d, take;
  logic            ovr_q, ovr_d;
  logic            load, sel_vld, sel_rise, sel_rep;
  logic [CW-1:0]   sel_idx;
  logic            evt_vld_q;
  evt_rec_t        evt_q;

  assign tick = (pcnt_q == PW'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pcnt_q  <= '0;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
      pcnt_q  <= tick ? '0 : pcnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_chan
    switch_debounce_chan #(
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
      .REPEAT_TICKS (REPEAT_TICKS),
`endif
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk_i       (CLK),
      .rst_i       (RST),
      .sw_s_i      (sync2_q[i]),
      .tick_i      (tick),
      .level_o     (level[i]),
      .post_o      (post[i]),
      .post_rise_o (post_rise[i]),
      .post_rep_o  (post_rep[i])
    );
  end

  assign load = !evt_vld_q || EVT_READY;

  // Lowest-index pending channel wins; take marks the one drained this cycle.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_rise = 1'b0;
    sel_rep  = 1'b0;
    take     = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (pend_q[i] && !sel_vld) begin
        sel_vld  = 1'b1;
        sel_idx  = CW'(i);
        sel_rise = pdir_q[i];
        sel_rep  = prep_q[i];
        take[i]  = load;
      end
    end
  end

  // A post into a slot being drained this cycle refills it without counting as overrun.
  always_comb begin
    pend_d = pend_q;
    pdir_d = pdir_q;
    prep_d = prep_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < N_SW; i++) begin
      if (post[i]) begin
        pend_d[i] = 1'b1;
        pdir_d[i] = post_rise[i];
        prep_d[i] = post_rep[i];
        if (pend_q[i] && !take[i]) ovr_d = 1'b1;
      end else if (take[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q    <= '0;
      pdir_q    <= '0;
      prep_q    <= '0;
      ovr_q     <= 1'b0;
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      pend_q <= pend_d;
      pdir_q <= pdir_d;
      prep_q <= prep_d;
      ovr_q  <= ovr_d;
      if (load) begin
        evt_vld_q <= sel_vld;
        if (sel_vld) begin
          evt_q.chan <= CHAN_MAX_W'(sel_idx);
          evt_q.rise <= sel_rise;
          evt_q.rep  <= sel_rep;
        end
      end
    end
  end

  assign STATE       = level;
  assign EVT_VALID   = evt_vld_q;
  assign EVT_CHAN    = CW'(evt_q.chan);
  assign EVT_RISE    = evt_q.rise;
  assign EVT_REPEAT  = evt_q.rep;
  assign EVT_OVERRUN = ovr_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with PRESCALE=4, STABLE_TICKS=3, REPEAT_TICKS=5, N_SW=4.
// Expectations for SWITCH_DEBOUNCER_AUTOREPEAT_EN follow the same macro.
module tb_switch_debouncer;

  localparam int N_SW = 4;
  localparam int CW   = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N_SW-1:0] SW = '0;
  logic [N_SW-1:0] STATE;
  logic            EVT_VALID, EVT_READY = 1'b1;
  logic [CW-1:0]   EVT_CHAN;
  logic            EVT_RISE, EVT_REPEAT, EVT_OVERRUN;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [3:0] rec_q[$];
  int         rec_t[$];
  logic       mon_en = 1'b0;
  logic       seen_hi = 1'b0;
  logic       stable_ok;

  always #5 CLK = ~CLK;

  switch_debouncer #(
    .N_SW         (4),
    .PRESCALE     (4),
    .STABLE_TICKS (3),
    .REPEAT_TICKS (5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SW          (SW),
    .STATE       (STATE),
    .EVT_VALID   (EVT_VALID),
    .EVT_READY   (EVT_READY),
    .EVT_CHAN    (EVT_CHAN),
    .EVT_RISE    (EVT_RISE),
    .EVT_REPEAT  (EVT_REPEAT),
    .EVT_OVERRUN (EVT_OVERRUN)
  );

  // Delivered records {chan, rise, repeat} with the cycle of their handshake.
  always @(posedge CLK) begin
    cyc++;
    if (!RST && EVT_VALID === 1'b1 && EVT_READY === 1'b1) begin
      rec_q.push_back({EVT_CHAN, EVT_RISE, EVT_REPEAT});
      rec_t.push_back(cyc);
    end
  end

  always @(negedge CLK) if (mon_en && STATE[1] !== 1'b0) seen_hi = 1'b1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] rec(input int i);
    return (i < rec_q.size()) ? rec_q[i] : 4'hF;
  endfunction

  function automatic int rec_gap(input int i);
    return (i + 1 < rec_t.size()) ? rec_t[i+1] - rec_t[i] : -1;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    rec_q.delete();
    rec_t.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   STATE,       0);
    chk({tag, "_valid"},   EVT_VALID,   0);
    chk({tag, "_chan"},    EVT_CHAN,    0);
    chk({tag, "_rise"},    EVT_RISE,    0);
    chk({tag, "_repeat"},  EVT_REPEAT,  0);
    chk({tag, "_overrun"}, EVT_OVERRUN, 0);
  endtask

  initial begin
    // Power-up reset
    do_reset();
    chk_all_zero("por");

    // Clean press on SW[0]: STATE at +12, record presented at +14
    SW[0] = 1'b1;
    step(11);
    chk("t1_state_early", STATE, 4'b0000);
    step(1);
    chk("t1_state_set", STATE, 4'b0001);
    step(1);
    chk("t1_valid_early", EVT_VALID, 0);
    step(1);
    chk("t1_valid", EVT_VALID, 1);
    chk("t1_chan", EVT_CHAN, 0);
    chk("t1_rise", EVT_RISE, 1);
    chk("t1_repeat", EVT_REPEAT, 0);
    step(16);
    chk("t1_count", rec_q.size(), 1);
    chk("t1_rec0", rec(0), 4'b0010);
    chk("t1_valid_drop", EVT_VALID, 0);

    // Bouncing SW[1]: 5-cycle pulses never settle, then a real hold
    SW = '0;
    do_reset();
    seen_hi = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      SW[1] = (k % 2 == 0);
      step(5);
    end
    mon_en = 1'b0;
    chk("t2_no_pulse", seen_hi, 0);
    chk("t2_no_rec_bounce", rec_q.size(), 0);
    SW[1] = 1'b1;
    step(20);
    chk("t2_state", STATE, 4'b0010);
    step(5);
    chk("t2_count", rec_q.size(), 1);
    chk("t2_rec0", rec(0), 4'b0110);

    // SW[1] and SW[3] together with the consumer stalled
    SW = '0;
    do_reset();
    EVT_READY = 1'b0;
    SW = 4'b1010;
    step(14);
    chk("t3_valid", EVT_VALID, 1);
    chk("t3_chan1", EVT_CHAN, 1);
    stable_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (!(EVT_VALID === 1'b1 && EVT_CHAN === 2'd1 && EVT_RISE === 1'b1 && EVT_REPEAT === 1'b0))
        stable_ok = 1'b0;
    end
    chk("t3_hold_stable", stable_ok, 1);
    chk("t3_state", STATE, 4'b1010);
    EVT_READY = 1'b1;
    step(1);
    chk("t3_valid_next", EVT_VALID, 1);
    chk("t3_chan3", EVT_CHAN, 3);
    step(1);
    chk("t3_valid_drop", EVT_VALID, 0);
    chk("t3_count", rec_q.size(), 2);
    chk("t3_rec0", rec(0), 4'b0110);
    chk("t3_rec1", rec(1), 4'b1110);
    chk("t3_b2b", rec_gap(0), 1);
    chk("t3_no_overrun", EVT_OVERRUN, 0);

    // Press, release, press on SW[2] while stalled: fall is overwritten
    SW = '0;
    do_reset();
    EVT_READY = 1'b0;
    SW[2] = 1'b1;
    step(14);
    chk("t4_first_chan", EVT_CHAN, 2);
    chk("t4_first_rise", EVT_RISE, 1);
    step(6);
    SW[2] = 1'b0;
    step(20);
    chk("t4_state_low", STATE, 4'b0000);
    chk("t4_no_overrun_yet", EVT_OVERRUN, 0);
    SW[2] = 1'b1;
    step(20);
    chk("t4_overrun", EVT_OVERRUN, 1);
    chk("t4_held_valid", EVT_VALID, 1);
    chk("t4_held_chan", EVT_CHAN, 2);
    EVT_READY = 1'b1;
    step(1);
    chk("t4_second_valid", EVT_VALID, 1);
    chk("t4_second_chan", EVT_CHAN, 2);
    chk("t4_second_rise", EVT_RISE, 1);
    chk("t4_second_repeat", EVT_REPEAT, 0);
    step(1);
    chk("t4_valid_drop", EVT_VALID, 0);
    chk("t4_count", rec_q.size(), 2);
    chk("t4_rec0", rec(0), 4'b1010);
    chk("t4_rec1", rec(1), 4'b1010);
    chk("t4_overrun_sticky", EVT_OVERRUN, 1);

    // Reset while SW[0] is mid-debounce and SW[2] still reads high
    EVT_READY = 1'b0;
    SW = 4'b0001;
    step(5);
    chk("t5_pre_state", STATE, 4'b0100);
    chk("t5_pre_overrun", EVT_OVERRUN, 1);
    do_reset();
    chk_all_zero("t5_rst");
    EVT_READY = 1'b1;
    step(11);
    chk("t5_state_early", STATE, 4'b0000);
    step(1);
    chk("t5_state_set", STATE, 4'b0001);
    step(2);
    chk("t5_valid", EVT_VALID, 1);
    chk("t5_chan", EVT_CHAN, 0);
    step(2);
    chk("t5_count", rec_q.size(), 1);

    // Long hold of SW[0] (50 ticks), then release
    SW = '0;
    do_reset();
    SW[0] = 1'b1;
    step(200);
    chk("t6_rec0", rec(0), 4'b0010);
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
    chk("t6_count", rec_q.size(), 10);
    chk("t6_rec1", rec(1), 4'b0011);
    chk("t6_rec9", rec(9), 4'b0011);
    chk("t6_gap", rec_gap(0), 20);
    chk("t6_gap2", rec_gap(1), 20);
`else
    chk("t6_count", rec_q.size(), 1);
    chk("t6_repeat_low", EVT_REPEAT, 0);
`endif
    SW[0] = 1'b0;
    step(20);
    chk("t6_state_low", STATE, 4'b0000);
`ifdef SWITCH_DEBOUNCER_AUTOREPEAT_EN
    chk("t6_count_rel", rec_q.size(), 11);
    chk("t6_fall", rec(10), 4'b0000);
`else
    chk("t6_count_rel", rec_q.size(), 2);
    chk("t6_fall", rec(1), 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-side counterpart to the board's direct LED drive: conditions the raw front-panel switches SW[N_SW-1:0].
- Synchronises and debounces each switch, then publishes a stable level vector.
- Turns each debounced edge into an event record on a valid/ready stream for downstream logic (LED controllers, mode registers).

Parameters:
- N_SW, 4, number of switch inputs (1..16).
- PRESCALE, 50000, CLK cycles per debounce tick (1 ms at 50 MHz); must be >= 2.
- STABLE_TICKS, 10, consecutive ticks a new level must hold before acceptance; must be >= 1.
- REPEAT_TICKS, 500, ticks between autorepeat events (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- SW  in  N_SW  raw asynchronous switch levels.
- STATE  out  N_SW  debounced levels.
- EVT_VALID  out  1  event record valid.
- EVT_READY  in  1  consumer accepts the record.
- EVT_CHAN  out  CW  channel index; CW = max(1, clog2(N_SW)).
- EVT_RISE  out  1  1 = press (0->1), 0 = release.
- EVT_REPEAT  out  1  record is an autorepeat; tied 0 when the feature is absent.
- EVT_OVERRUN  out  1  sticky; an event was overwritten before delivery.

Behaviour:
- Reset: one clock, synchronous, active-high, on CLK rising edge. All registers clear. STATE=0, EVT_VALID=0, EVT_CHAN=0, EVT_RISE=0, EVT_REPEAT=0, EVT_OVERRUN=0.
- Synchroniser: 2-flop per bit. The synced value sw_s lags SW by 2 cycles.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - tick is a 1-cycle pulse when pcnt==PRESCALE-1.
  - Shared by all channels.
- Per-channel FSM, states LOW, CHK_HIGH, HIGH, CHK_LOW:
  - LOW: sw_s=1 -> CHK_HIGH, cnt=0.
  - CHK_HIGH:
    - sw_s=0 -> LOW, no event.
    - Otherwise on tick, cnt++.
    - On the tick where cnt==STABLE_TICKS-1 and sw_s=1 -> HIGH; STATE bit=1; post rise event.
  - HIGH / CHK_LOW: mirror of the above. Acceptance posts a fall event and clears the STATE bit.
  - cnt width = clog2(STABLE_TICKS+1); it never wraps.
  - Latency from a clean edge to STATE: 2 sync cycles + up to STABLE_TICKS*PRESCALE cycles.
- Pending store, per channel: pend, pdir, prep.
  - Posting an event sets pend and writes pdir/prep.
  - Posting while pend=1 and the same channel is not being loaded that cycle: overwrite pdir/prep, set EVT_OVERRUN. EVT_OVERRUN clears only on RST.
- Output register / arbiter:
  - Loads when EVT_VALID=0 or (EVT_VALID & EVT_READY).
  - Selects the lowest-index channel with pend=1 and clears that pend in the same cycle.
  - Channel loaded and posting in the same cycle: the old record is delivered, pend stays 1 with the new data, no overrun.
  - While EVT_VALID & !EVT_READY, all EVT_* outputs hold stable.
  - No pending events -> EVT_VALID drops after a handshake.
  - Throughput: one record per cycle.
- Simultaneous debounced edges on several channels: all are posted; delivery order is ascending index.
- RST mid-debounce or mid-handshake: the in-flight record and pendings are discarded. A switch held high through reset re-debounces from LOW and yields a fresh rise event.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - In HIGH, a repeat counter counts ticks; it clears on entry to HIGH.
  - Every REPEAT_TICKS ticks it posts a rise event with EVT_REPEAT=1.
  - Leaving HIGH stops it.
- Undefined: no repeat counter exists; EVT_REPEAT is constant 0.

Decomposition:
- Package switch_debouncer_pkg:
  - FSM state encoding (2-bit: LOW, CHK_HIGH, HIGH, CHK_LOW).
  - CW derivation function.
  - Event record layout {chan, rise, repeat}.
- Sub-module switch_debounce_chan, instantiated N_SW times:
  - Inputs: CLK, RST, sw_s, tick.
  - Outputs: level, post, post_rise, post_rep.
  - Contains the FSM, cnt and (optional) repeat counter.
- Top level holds the synchroniser, prescaler, pending store and arbiter.

Test Plan (PRESCALE=4, STABLE_TICKS=3, REPEAT_TICKS=5, N_SW=4, EVT_READY=1 unless stated):
- SW[0] 0->1 held -> STATE[0]=1 within 2+12 cycles; exactly one record {chan0, rise=1}; no further records.
- SW[1] toggles every 5 cycles for 40 cycles, then holds 1 -> STATE[1] never pulses during bounce; exactly one rise record after settling.
- SW[1] and SW[3] rise on the same cycle, EVT_READY=0 for 30 cycles -> EVT_VALID=1 with chan1 held stable throughout; after READY, chan3 follows on the next cycle.
- EVT_READY=0; SW[2] press, release, press (each settled) -> first record chan2 rise; second chan2 rise (overwrote the fall); EVT_OVERRUN=1.
- RST for 1 cycle while SW[0]=1 in CHK_HIGH -> all outputs 0 the next cycle; a rise record arrives only after a full re-debounce.
- With SWITCH_DEBOUNCER_AUTOREPEAT_EN, SW[0] held 50 ticks -> initial rise, then repeat records every 20 cycles with EVT_REPEAT=1. Without the macro -> a single record.
